// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder with valid/ready handshakes on both sides.
// A two-entry buffer (OUT + SKID) keeps full throughput under back-pressure while
// in_ready stays a pure function of registered state.
// Optional feature: define DECODER_ILLEGAL_EN to flag unrecognised opcodes on `illegal`.
//
// Select encodings
//   alu_op_sel : 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and
//   src_a_sel  : 0 rs1, 1 pc, 2 zero
//   src_b_sel  : 0 rs2, 1 imm, 2 constant four
module decode_stage #(
    parameter int unsigned XLEN = 32,
    parameter bit RD0_NO_WR = 1'b1,
    localparam int unsigned ALU_OP_WIDTH = 4,
    localparam int unsigned SEL_SRC_A_WIDTH = 2,
    localparam int unsigned SEL_SRC_B_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                code,
    input  logic [XLEN-1:0]            pc_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4:0]                 rs1_num,
    output logic [4:0]                 rs2_num,
    output logic [4:0]                 rd_num,
    output logic [XLEN-1:0]            imm,
    output logic [ALU_OP_WIDTH-1:0]    alu_op_sel,
    output logic [SEL_SRC_A_WIDTH-1:0] src_a_sel,
    output logic [SEL_SRC_B_WIDTH-1:0] src_b_sel,
    output logic                       wr_reg,
    output logic                       illegal,
    output logic [XLEN-1:0]            pc_out
);

    // Major opcodes
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    localparam logic [ALU_OP_WIDTH-1:0] AluAdd  = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] AluSub  = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] AluSll  = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] AluSlt  = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] AluSltu = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] AluXor  = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] AluSrl  = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] AluSra  = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] AluOr   = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] AluAnd  = 4'd9;

    localparam logic [SEL_SRC_A_WIDTH-1:0] SrcARs1  = 2'd0;
    localparam logic [SEL_SRC_A_WIDTH-1:0] SrcAPc   = 2'd1;
    localparam logic [SEL_SRC_A_WIDTH-1:0] SrcAZero = 2'd2;

    localparam logic [SEL_SRC_B_WIDTH-1:0] SrcBRs2  = 2'd0;
    localparam logic [SEL_SRC_B_WIDTH-1:0] SrcBImm  = 2'd1;
    localparam logic [SEL_SRC_B_WIDTH-1:0] SrcBFour = 2'd2;

    typedef struct packed {
        logic [4:0]                 rs1;
        logic [4:0]                 rs2;
        logic [4:0]                 rd;
        logic [XLEN-1:0]            imm;
        logic [ALU_OP_WIDTH-1:0]    alu_op;
        logic [SEL_SRC_A_WIDTH-1:0] src_a;
        logic [SEL_SRC_B_WIDTH-1:0] src_b;
        logic                       wr;
        logic                       ill;
        logic [XLEN-1:0]            pc;
    } payload_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e   state_q, state_d;
    payload_t out_q, skid_q;
    payload_t dec;
    logic     accept, out_fire;
    logic     load_out_new, load_out_skid, load_skid;

    // funct7[5] only selects sub for register-register ops; addi has no sub form
    function automatic logic [ALU_OP_WIDTH-1:0] alu_from_funct(input logic [2:0] funct3,
                                                               input logic       bit30,
                                                               input logic       is_reg);
        logic [ALU_OP_WIDTH-1:0] op;
        unique case (funct3)
            3'b000:  op = (is_reg && bit30) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = bit30 ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    // Combinational decode of the incoming word into the payload format
    always_comb begin
        logic [31:0] imm32;
        imm32      = 32'd0;
        dec        = '0;
        dec.rs1    = code[19:15];
        dec.rs2    = code[24:20];
        dec.rd     = code[11:7];
        dec.pc     = pc_in;
        dec.alu_op = AluAdd;
        dec.src_a  = SrcARs1;
        dec.src_b  = SrcBRs2;
        case (code[6:0])
            OpcOp: begin
                dec.alu_op = alu_from_funct(code[14:12], code[30], 1'b1);
                dec.wr     = 1'b1;
            end
            OpcOpImm: begin
                imm32      = {{20{code[31]}}, code[31:20]};
                dec.alu_op = alu_from_funct(code[14:12], code[30], 1'b0);
                dec.src_b  = SrcBImm;
                dec.wr     = 1'b1;
            end
            OpcLoad: begin
                imm32     = {{20{code[31]}}, code[31:20]};
                dec.src_b = SrcBImm;
                dec.wr    = 1'b1;
            end
            OpcJalr: begin
                // ALU forms the link value pc+4; the target uses imm downstream
                imm32     = {{20{code[31]}}, code[31:20]};
                dec.src_a = SrcAPc;
                dec.src_b = SrcBFour;
                dec.wr    = 1'b1;
            end
            OpcStore: begin
                imm32     = {{20{code[31]}}, code[31:25], code[11:7]};
                dec.src_b = SrcBImm;
            end
            OpcBranch: begin
                // ALU compares rs1 against rs2
                imm32      = {{19{code[31]}}, code[31], code[7], code[30:25], code[11:8], 1'b0};
                dec.alu_op = AluSub;
            end
            OpcLui: begin
                imm32     = {code[31:12], 12'd0};
                dec.src_a = SrcAZero;
                dec.src_b = SrcBImm;
                dec.wr    = 1'b1;
            end
            OpcAuipc: begin
                imm32     = {code[31:12], 12'd0};
                dec.src_a = SrcAPc;
                dec.src_b = SrcBImm;
                dec.wr    = 1'b1;
            end
            OpcJal: begin
                imm32     = {{11{code[31]}}, code[31], code[19:12], code[20], code[30:21], 1'b0};
                dec.src_a = SrcAPc;
                dec.src_b = SrcBFour;
                dec.wr    = 1'b1;
            end
            default: begin
                // Unknown opcode: imm and wr stay 0; the entry still flows through
`ifdef DECODER_ILLEGAL_EN
                dec.ill = 1'b1;
`endif
            end
        endcase
        dec.imm = XLEN'($signed(imm32));
        if (RD0_NO_WR && (code[11:7] == 5'd0)) begin
            dec.wr = 1'b0;
        end
    end

    assign out_valid = (state_q != StEmpty);
    assign in_ready  = (state_q != StFull);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Buffer occupancy next-state and register load controls; flush overrides all
    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    load_out_new = 1'b1;
                    state_d      = StOne;
                end
            end
            StOne: begin
                if (out_fire && accept) begin
                    load_out_new = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = StFull;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_fire) begin
                    load_out_skid = 1'b1;
                    state_d       = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d       = StEmpty;
            load_out_new  = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
        end
    end

    // State and payload registers; reset also clears the payload so outputs read 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_out_new) begin
                out_q <= dec;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign rs1_num    = out_q.rs1;
    assign rs2_num    = out_q.rs2;
    assign rd_num     = out_q.rd;
    assign imm        = out_q.imm;
    assign alu_op_sel = out_q.alu_op;
    assign src_a_sel  = out_q.src_a;
    assign src_b_sel  = out_q.src_b;
    assign wr_reg     = out_q.wr;
    // Constant 0 unless DECODER_ILLEGAL_EN is defined, since decode never sets it
    assign illegal    = out_q.ill;
    assign pc_out     = out_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a queue-based occupancy/payload model is
// compared against the DUT every cycle, plus directed checks of the known encodings.
module tb_decode_stage;

    localparam int unsigned XLEN = 32;

`ifdef DECODER_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    // Expected select codes by meaning
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3;
    localparam logic [3:0] A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7;
    localparam logic [3:0] A_OR = 4'd8, A_AND = 4'd9;
    localparam logic [1:0] SA_RS1 = 2'd0, SA_PC = 2'd1, SA_ZERO = 2'd2;
    localparam logic [1:0] SB_RS2 = 2'd0, SB_IMM = 2'd1, SB_FOUR = 2'd2;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [1:0]  sa, sb;
        logic        wr, ill;
        logic [31:0] pc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     code;
    logic [XLEN-1:0] pc_in, pc_out, imm;
    logic [4:0]      rs1_num, rs2_num, rd_num;
    logic [3:0]      alu_op_sel;
    logic [1:0]      src_a_sel, src_b_sel;
    logic            wr_reg, illegal;

    int   total = 0;
    int   bad = 0;
    int   popped = 0;
    exp_t q[$];
    logic [31:0] pc_ctr = 32'h1000;

    decode_stage #(.XLEN(XLEN), .RD0_NO_WR(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .code(code), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
        .rs1_num(rs1_num), .rs2_num(rs2_num), .rd_num(rd_num), .imm(imm),
        .alu_op_sel(alu_op_sel), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
        .wr_reg(wr_reg), .illegal(illegal), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Two's-complement value of the low n bits of x
    function automatic longint sext(input longint x, input int n);
        longint m;
        m = x & ((longint'(1) << n) - 1);
        if (m >= (longint'(1) << (n - 1))) m = m - (longint'(1) << n);
        return m;
    endfunction

    function automatic logic [3:0] alu_for(input logic [31:0] c, input bit is_reg);
        int f3;
        bit b30;
        f3  = int'((c >> 12) & 7);
        b30 = c[30];
        case (f3)
            0: return (is_reg && b30) ? A_SUB : A_ADD;
            1: return A_SLL;
            2: return A_SLT;
            3: return A_SLTU;
            4: return A_XOR;
            5: return b30 ? A_SRA : A_SRL;
            6: return A_OR;
            default: return A_AND;
        endcase
    endfunction

    // Reference decode, built from field values with integer arithmetic
    function automatic exp_t model(input logic [31:0] c, input logic [31:0] pc);
        exp_t   e;
        longint v;
        longint u;
        u = longint'(c);
        v = 0;
        e.rs1 = c[19:15]; e.rs2 = c[24:20]; e.rd = c[11:7]; e.pc = pc;
        e.alu = A_ADD; e.sa = SA_RS1; e.sb = SB_RS2; e.wr = 1'b0; e.ill = 1'b0;
        case (int'(u & 127))
            'h33: begin e.alu = alu_for(c, 1'b1); e.wr = 1'b1; end
            'h13: begin v = sext(u >> 20, 12); e.alu = alu_for(c, 1'b0); e.sb = SB_IMM; e.wr = 1'b1; end
            'h03: begin v = sext(u >> 20, 12); e.sb = SB_IMM; e.wr = 1'b1; end
            'h67: begin v = sext(u >> 20, 12); e.sa = SA_PC; e.sb = SB_FOUR; e.wr = 1'b1; end
            'h23: begin v = sext(((u >> 25) << 5) + ((u >> 7) & 31), 12); e.sb = SB_IMM; end
            'h63: begin
                v = sext(((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048
                         + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2, 13);
                e.alu = A_SUB;
            end
            'h37: begin v = sext(u >> 12, 20) * 4096; e.sa = SA_ZERO; e.sb = SB_IMM; e.wr = 1'b1; end
            'h17: begin v = sext(u >> 12, 20) * 4096; e.sa = SA_PC; e.sb = SB_IMM; e.wr = 1'b1; end
            'h6F: begin
                v = sext(((u >> 31) & 1) * (1 << 20) + ((u >> 12) & 255) * 4096
                         + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2, 21);
                e.sa = SA_PC; e.sb = SB_FOUR; e.wr = 1'b1;
            end
            default: e.ill = ILL_EN;
        endcase
        if (e.rd == 5'd0) e.wr = 1'b0;
        e.imm = v[31:0];
        return e;
    endfunction

    function automatic logic [31:0] rand_code();
        logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        logic [31:0] c;
        c = $urandom;
        if ($urandom_range(0, 9) == 0) c[6:0] = 7'($urandom);
        else c[6:0] = ops[$urandom_range(0, 8)];
        return c;
    endfunction

    // Check outputs against the model mid-cycle, then advance the model over the edge
    task automatic cycle();
        bit acc, pop;
        @(negedge clk);
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("rs1", rs1_num, q[0].rs1);
            chk("rs2", rs2_num, q[0].rs2);
            chk("rd", rd_num, q[0].rd);
            chk("imm", imm, q[0].imm);
            chk("alu", alu_op_sel, q[0].alu);
            chk("src_a", src_a_sel, q[0].sa);
            chk("src_b", src_b_sel, q[0].sb);
            chk("wr_reg", wr_reg, q[0].wr);
            chk("illegal", illegal, q[0].ill);
            chk("pc_out", pc_out, q[0].pc);
        end
        acc = in_valid && (q.size() < 2);
        pop = out_ready && (q.size() > 0);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (acc) q.push_back(model(code, pc_in));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] c);
        code = c; pc_in = pc_ctr; pc_ctr += 4; in_valid = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ov"}, out_valid, 1'b0);
        chk({tag, "_ir"}, in_ready, 1'b1);
        chk({tag, "_payload"}, {rs1_num, rs2_num, rd_num, alu_op_sel, src_a_sel, src_b_sel,
                                 wr_reg, illegal}, '0);
        chk({tag, "_imm"}, imm, 0);
        chk({tag, "_pc"}, pc_out, 0);
    endtask

    initial begin
        int start, sent;
        logic [31:0] words [8];
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; code = '0; pc_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_zero("reset");

        // I-type
        out_ready = 1'b1;
        drive(32'b111100001111_00001_000_00010_0010011); cycle(); in_valid = 1'b0;
        chk("i_rs1", rs1_num, 1); chk("i_rd", rd_num, 2);
        chk("i_imm", imm, 32'hFFFFFF0F); chk("i_wr", wr_reg, 1); chk("i_alu", alu_op_sel, A_ADD);
        cycle();
        // S-type
        drive(32'b1111111_00001_00010_000_00000_0100011); cycle(); in_valid = 1'b0;
        chk("s_rs1", rs1_num, 2); chk("s_rs2", rs2_num, 1);
        chk("s_imm", imm, 32'hFFFFFFE0); chk("s_wr", wr_reg, 0);
        cycle();
        // B-type
        drive(32'b0_010001_00010_00001_000_0101_1_1100011); cycle(); in_valid = 1'b0;
        chk("b_imm", imm, 32'h00000A2A); chk("b_wr", wr_reg, 0);
        cycle();
        // U-type
        drive(32'b11110000111100001111_00001_0110111); cycle(); in_valid = 1'b0;
        chk("u_imm", imm, 32'hF0F0F000); chk("u_rd", rd_num, 1);
        cycle();
        // J-type
        drive(32'b1_0000000000_1_00000000_00001_1101111); cycle(); in_valid = 1'b0;
        chk("j_imm", imm, 32'hFFF00800); chk("j_wr", wr_reg, 1);
        cycle();
        // Unknown opcode
        drive(32'h0000007F); cycle(); in_valid = 1'b0;
        chk("ill_flag", illegal, ILL_EN); chk("ill_wr", wr_reg, 0); chk("ill_imm", imm, 0);
        cycle();
        // rd = x0 never writes
        drive(32'h00500013); cycle(); in_valid = 1'b0;
        chk("rd0_wr", wr_reg, 0);
        cycle();

        // Back-pressure: 8 words, out_ready pattern 1,0,0,1
        for (int i = 0; i < 8; i++) words[i] = rand_code();
        start = popped; sent = 0;
        for (int k = 0; k < 80 && (popped - start) < 8; k++) begin
            bit acc;
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            if (sent < 8) drive(words[sent]); else in_valid = 1'b0;
            acc = in_valid && (q.size() < 2);
            cycle();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("bp_delivered", popped - start, 8);

        // Flush while FULL with a concurrent valid word
        out_ready = 1'b0;
        drive(rand_code()); cycle();
        drive(rand_code()); cycle();
        chk("full_ir", in_ready, 0);
        drive(rand_code()); flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_ov", out_valid, 0); chk("flush_ir", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) cycle();

        // Reset while FULL
        out_ready = 1'b0;
        drive(rand_code()); cycle();
        drive(rand_code()); cycle();
        in_valid = 1'b1; rst = 1'b1; cycle();
        rst = 1'b0; in_valid = 1'b0;
        check_zero("rst_full");

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                code = rand_code(); pc_in = $urandom; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 49) == 0);
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cycle();
        chk("drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
